piso_tx: RTL and testbench

Parallel-in serial-out frame transmitter that drives a single-bit serial line for the team's shift-register receivers. It accepts a WIDTH-bit word over a valid/ready handshake, then emits a framed bit stream MSB first: start bit, data, and an optional parity bit. Each bit is held for a programmable number of clock cycles.

---
 rtl/piso_tx.sv | 129 ++++++++++++
 tb/tb_piso_tx.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/piso_tx.sv
// Framed parallel-in serial-out transmitter: start bit, data MSB first, optional even parity.
// Build option: define PISO_TX_PARITY_EN to append the parity bit after the data bits.
module piso_tx #(
    parameter int unsigned WIDTH        = 8,
    parameter int unsigned CLKS_PER_BIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             srl_out,
    output logic             busy,
    output logic             done
);

    localparam int unsigned HoldW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned BitW  = $clog2(WIDTH);
    localparam logic [HoldW-1:0] HoldLast = HoldW'(CLKS_PER_BIT - 1);
    localparam logic [BitW-1:0]  BitLast  = BitW'(WIDTH - 1);

`ifdef PISO_TX_PARITY_EN
    typedef enum logic [1:0] {StIdle, StStart, StData, StParity} state_e;
`else
    typedef enum logic [1:0] {StIdle, StStart, StData} state_e;
`endif

    state_e             r_state_q, w_state_d;
    logic [HoldW-1:0]   r_hold_q, w_hold_d;
    logic [BitW-1:0]    r_bit_q, w_bit_d;
    logic [WIDTH-1:0]   r_shreg_q, w_shreg_d;
    logic               r_srl_q, w_srl_d;
    logic               r_done_q, w_done_d;
    logic               w_bit_end;
`ifdef PISO_TX_PARITY_EN
    logic               r_par_q, w_par_d;
`endif

    assign w_bit_end = (r_hold_q == HoldLast);

    always_comb begin
        w_state_d = r_state_q;
        w_hold_d  = w_bit_end ? '0 : r_hold_q + HoldW'(1);
        w_bit_d   = r_bit_q;
        w_shreg_d = r_shreg_q;
`ifdef PISO_TX_PARITY_EN
        w_par_d   = r_par_q;
`endif
        case (r_state_q)
            StIdle: begin
                w_hold_d = '0;
                if (din_valid) begin
                    w_shreg_d = din;
`ifdef PISO_TX_PARITY_EN
                    w_par_d   = ^din;
`endif
                    w_state_d = StStart;
                end
            end
            StStart: begin
                if (w_bit_end) w_state_d = StData;
            end
            StData: begin
                if (w_bit_end) begin
                    w_shreg_d = {r_shreg_q[WIDTH-2:0], 1'b0};
                    if (r_bit_q == BitLast) begin
                        w_bit_d = '0;
`ifdef PISO_TX_PARITY_EN
                        w_state_d = StParity;
`else
                        w_state_d = StIdle;
`endif
                    end else begin
                        w_bit_d = r_bit_q + BitW'(1);
                    end
                end
            end
`ifdef PISO_TX_PARITY_EN
            StParity: begin
                if (w_bit_end) w_state_d = StIdle;
            end
`endif
            default: w_state_d = StIdle;
        endcase
    end

    // Line level is decoded from the next state so the registered output lines up with it.
    always_comb begin
        case (w_state_d)
            StStart:  w_srl_d = 1'b1;
            StData:   w_srl_d = w_shreg_d[WIDTH-1];
`ifdef PISO_TX_PARITY_EN
            StParity: w_srl_d = w_par_d;
`endif
            default:  w_srl_d = 1'b0;
        endcase
        w_done_d = (r_state_q != StIdle) && (w_state_d == StIdle);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q <= StIdle;
            r_hold_q  <= '0;
            r_bit_q   <= '0;
            r_shreg_q <= '0;
            r_srl_q   <= 1'b0;
            r_done_q  <= 1'b0;
`ifdef PISO_TX_PARITY_EN
            r_par_q   <= 1'b0;
`endif
        end else begin
            r_state_q <= w_state_d;
            r_hold_q  <= w_hold_d;
            r_bit_q   <= w_bit_d;
            r_shreg_q <= w_shreg_d;
            r_srl_q   <= w_srl_d;
            r_done_q  <= w_done_d;
`ifdef PISO_TX_PARITY_EN
            r_par_q   <= w_par_d;
`endif
        end
    end

    assign din_ready = (r_state_q == StIdle);
    assign busy      = (r_state_q != StIdle);
    assign srl_out   = r_srl_q;
    assign done      = r_done_q;

endmodule

// File: tb/tb_piso_tx.sv
// Bench for piso_tx: two instances (1 and 3 clocks per bit) against a frame-position model.
module tb_piso_tx;

    localparam int W  = 8;
    localparam int CA = 1;
    localparam int CB = 3;
`ifdef PISO_TX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    localparam int FA = (1 + W + P) * CA;
    localparam int FB = (1 + W + P) * CB;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] din;
    logic         din_valid;
    logic         ready_a, srl_a, busy_a, done_a;
    logic         ready_b, srl_b, busy_b, done_b;

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    piso_tx #(.WIDTH(W), .CLKS_PER_BIT(CA)) u_dut_a (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
        .din_ready(ready_a), .srl_out(srl_a), .busy(busy_a), .done(done_a)
    );

    piso_tx #(.WIDTH(W), .CLKS_PER_BIT(CB)) u_dut_b (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
        .din_ready(ready_b), .srl_out(srl_b), .busy(busy_b), .done(done_b)
    );

    // Model: pos is the cycle offset inside the current frame, -1 when idle.
    int           pos_a = -1, pos_b = -1;
    logic [W-1:0] word_a = '0, word_b = '0;
    bit           dn_a = 1'b0, dn_b = 1'b0;

    function automatic logic frame_bit(input int c, input logic [W-1:0] w, input int pos);
        int b = pos / c;
        if (b == 0) return 1'b1;
        if (b <= W) return w[W-b];
        return ^w;
    endfunction

    task automatic step(input int f, inout int pos, inout logic [W-1:0] w, inout bit dn);
        if (rst) begin
            pos = -1;
            dn  = 1'b0;
        end else if (pos < 0) begin
            dn = 1'b0;
            if (din_valid) begin
                w   = din;
                pos = 0;
            end
        end else begin
            pos++;
            if (pos == f) begin
                pos = -1;
                dn  = 1'b1;
            end
        end
    endtask

    always @(posedge clk) begin
        step(FA, pos_a, word_a, dn_a);
        step(FB, pos_b, word_b, dn_b);
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("a_srl", 16'(srl_a), 16'(pos_a >= 0 ? frame_bit(CA, word_a, pos_a) : 1'b0));
            chk("a_busy", 16'(busy_a), 16'(pos_a >= 0));
            chk("a_ready", 16'(ready_a), 16'(pos_a < 0));
            chk("a_done", 16'(done_a), 16'(dn_a));
            chk("b_srl", 16'(srl_b), 16'(pos_b >= 0 ? frame_bit(CB, word_b, pos_b) : 1'b0));
            chk("b_busy", 16'(busy_b), 16'(pos_b >= 0));
            chk("b_ready", 16'(ready_b), 16'(pos_b < 0));
            chk("b_done", 16'(done_b), 16'(dn_b));
        end
    end

    task automatic wait_idle(input string name);
        int n = 0;
        while ((busy_a || busy_b || done_a || done_b) && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk(name, 16'(n < 100), 16'd1);
    endtask

    logic [10:0] rec_srl, rec_busy, rec_done;
    logic [15:0] exp_v;
    int          ones, done_at, prev_rise, gap;
    logic        prev_busy;

    initial begin
        // Power-up: reset held 2 cycles with a word already offered.
        rst       = 1'b1;
        din_valid = 1'b1;
        din       = 8'hA5;
        @(negedge clk);
        chk_en = 1'b1;
        chk("pwr_srl", 16'(srl_a), 16'd0);
        chk("pwr_done", 16'(done_a), 16'd0);
        @(negedge clk);
        chk("pwr_busy", 16'(busy_a), 16'd0);
        rst = 1'b0;
        // First edge after reset accepts A5; record cycles N+1..N+11 on instance a.
        @(negedge clk);
        din_valid = 1'b0;
        for (int k = 0; k < 11; k++) begin
            din = 8'($urandom);
            rec_srl[10-k]  = srl_a;
            rec_busy[10-k] = busy_a;
            rec_done[10-k] = done_a;
            @(negedge clk);
        end
        exp_v = 16'(11'b11010010100);
        chk("a5_srl", 16'(rec_srl), exp_v);
`ifdef PISO_TX_PARITY_EN
        exp_v = 16'(11'b11111111110);
        chk("a5_busy", 16'(rec_busy), exp_v);
        exp_v = 16'(11'b00000000001);
        chk("a5_done", 16'(rec_done), exp_v);
`else
        exp_v = 16'(11'b11111111100);
        chk("a5_busy", 16'(rec_busy), exp_v);
        exp_v = 16'(11'b00000000010);
        chk("a5_done", 16'(rec_done), exp_v);
`endif
        wait_idle("idle_1");

        // Bit hold on instance b with 8'h80.
        din       = 8'h80;
        din_valid = 1'b1;
        @(negedge clk);
        din_valid = 1'b0;
        ones    = 0;
        done_at = 0;
        for (int k = 1; k < 60 && done_at == 0; k++) begin
            din = 8'($urandom);
            if (srl_b) ones++;
            if (done_b) done_at = k;
            @(negedge clk);
        end
`ifdef PISO_TX_PARITY_EN
        chk("hold_done_at", 16'(done_at), 16'd31);
        chk("hold_ones", 16'(ones), 16'd9);
`else
        chk("hold_done_at", 16'(done_at), 16'd28);
        chk("hold_ones", 16'(ones), 16'd6);
`endif
        wait_idle("idle_2");

        // Reset during data bit 3 of 8'hFF on instance a, then send 8'h3C.
        din       = 8'hFF;
        din_valid = 1'b1;
        @(negedge clk);
        din_valid = 1'b0;
        repeat (4) @(negedge clk);
        chk("rst_pre_srl", 16'(srl_a), 16'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_srl", 16'(srl_a), 16'd0);
        chk("rst_busy", 16'(busy_a), 16'd0);
        chk("rst_ready", 16'(ready_a), 16'd1);
        chk("rst_done", 16'(done_a), 16'd0);
        rst       = 1'b0;
        din       = 8'h3C;
        din_valid = 1'b1;
        @(negedge clk);
        chk("rst_nodone", 16'(done_a), 16'd0);
        din_valid = 1'b0;
        wait_idle("idle_3");

        // Continuous valid: 8'h01 first, then changing words; accepts spaced F+1 apart.
        din       = 8'h01;
        din_valid = 1'b1;
        prev_busy = 1'b0;
        prev_rise = -1;
        for (int t = 0; t < 4 * (FA + 1); t++) begin
            @(negedge clk);
            din = (t == 0) ? 8'hFE : 8'($urandom);
            if (busy_a && !prev_busy) begin
                if (prev_rise >= 0) begin
                    gap = t - prev_rise;
`ifdef PISO_TX_PARITY_EN
                    chk("b2b_gap", 16'(gap), 16'd11);
`else
                    chk("b2b_gap", 16'(gap), 16'd10);
`endif
                end
                prev_rise = t;
            end
            prev_busy = busy_a;
        end
        din_valid = 1'b0;
        wait_idle("idle_4");

        // Random traffic with occasional resets.
        for (int t = 0; t < 3000; t++) begin
            rst       = ($urandom_range(0, 199) == 0);
            din_valid = ($urandom_range(0, 3) != 0);
            din       = 8'($urandom);
            @(negedge clk);
        end
        rst       = 1'b0;
        din_valid = 1'b0;
        repeat (40) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
